// File: rtl/addsub_pkg.sv
// Shared definitions for the segmented pipelined adder/subtractor:
// op encoding, stage-count helper and the per-stage control payload.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Control half of a stage payload; the operand/partial-sum half depends on
  // the stage index and is declared per stage in the top.
  typedef struct packed {
    logic carry;
    logic valid;
  } seg_ctl_t;

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead slice built from generate/propagate
// terms; also exposes the carry into its MSB for signed-overflow detection.
module cla_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [SEG_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin : p_carry
    logic run;
    run = 1'b0;
    c   = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      c[i+1] = g[i];
      run    = p[i];
      for (int unsigned j = 0; j < i; j++) begin
        c[i+1] = c[i+1] | (run & g[i-1-j]);
        run    = run & p[i-1-j];
      end
      c[i+1] = c[i+1] | (run & cin);
    end
  end

  assign s        = p ^ c[SEG_W-1:0];
  assign cout     = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined segmented adder/subtractor: one lookahead slice per stage, carry
// registered between stages, global-stall valid/ready handshake.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // acc holds {partial sum so far, unprocessed A bits}: every stage shifts it
  // right by SEG_W and inserts its sum slice at the top, so after the last
  // stage it is the full result. b shrinks to the unprocessed bits only.
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int BW = WIDTH - k * SEG_W;

    logic [WIDTH-1:0] acc;
    logic [BW-1:0]    b;
    seg_ctl_t         ctl;
    logic [SEG_W-1:0] s;
    logic             cout;
    logic             c_msb;
    logic [WIDTH-1:0] acc_nxt;

    cla_seg #(.SEG_W(SEG_W)) u_cla (
      .a        (acc[SEG_W-1:0]),
      .b        (b[SEG_W-1:0]),
      .cin      (ctl.carry),
      .s        (s),
      .cout     (cout),
      .c_msb_in (c_msb)
    );

    if (NSEG == 1) begin : g_one
      assign acc_nxt = s;
    end else begin : g_many
      assign acc_nxt = {s, acc[WIDTH-1:SEG_W]};
    end

    if (k != NSEG - 1) begin : g_mid
      logic unused_c_msb;
      assign unused_c_msb = c_msb;
    end

    if (k == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc <= '0;
          b   <= '0;
          ctl <= '0;
        end else if (adv) begin
          ctl.valid <= in_valid;
          if (in_valid) begin
            acc       <= in_a;
            b         <= (in_sub == OP_SUB) ? ~in_b : in_b;
            ctl.carry <= (in_sub == OP_ADD) ? in_cin : 1'b1;
          end
        end
      end
    end else begin : g_next
      localparam int PBW = WIDTH - (k - 1) * SEG_W;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc <= '0;
          b   <= '0;
          ctl <= '0;
        end else if (adv) begin
          acc       <= g_seg[k-1].acc_nxt;
          b         <= g_seg[k-1].b[PBW-1:SEG_W];
          ctl.carry <= g_seg[k-1].cout;
          ctl.valid <= g_seg[k-1].ctl.valid;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b1;
    end else if (adv) begin
      out_valid <= g_seg[NSEG-1].ctl.valid;
      out_sum   <= g_seg[NSEG-1].acc_nxt;
      out_cout  <= g_seg[NSEG-1].cout;
      out_ovf   <= g_seg[NSEG-1].cout ^ g_seg[NSEG-1].c_msb;
      out_zero  <= (g_seg[NSEG-1].acc_nxt == '0);
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: driver pushes model results on accept,
// an independent monitor pops and compares on every output transfer.
module tb_pipe_addsub;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic; overflow is "true signed result out of range".
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t            e;
    longint          sa = $signed(a);
    longint          sbv = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned full;
    longint          sres;
    if (sub) begin
      full   = ua - ub;
      e.cout = (ua >= ub);
      sres   = sa - sbv;
    end else begin
      full   = ua + ub + longint'(cin);
      e.cout = full[WIDTH];
      sres   = sa + sbv + longint'(cin);
    end
    e.sum     = full[WIDTH-1:0];
    e.ovf     = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    e.zero    = (e.sum == '0);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Called at a negedge; returns at the following negedge after the beat is accepted.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input bit lat, input bit rnd_ready);
    exp_t e;
    int   n = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    forever begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (in_ready) begin
        e = model(a, b, cin, sub);
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        @(negedge clk);
        break;
      end
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_ready);
    in_valid = 1'b0;
    repeat (n) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Monitor: output transfer check plus hold-stable check under backpressure.
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] prev_sum;
  logic [3:0]       prev_flags;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_sum", out_sum, prev_sum);
        chk("hold_flags", {out_valid, out_cout, out_ovf, out_zero}, prev_flags);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sum", out_sum, e.sum);
          chk("cout", out_cout, e.cout);
          chk("ovf", out_ovf, e.ovf);
          chk("zero", out_zero, e.zero);
          if (e.chk_lat) chk("latency", cyc - e.acc_cyc - 1, LAT);
        end
      end
    end
    hold_prev  = rst_n && out_valid && !out_ready;
    prev_sum   = out_sum;
    prev_flags = {out_valid, out_cout, out_ovf, out_zero};
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry chain, signed overflow, borrow
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1, 0);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1, 0);
    send(32'h5, 32'h7, 1'b1, 1'b1, 1, 0);
    idle(8, 0);

    // Back-to-back stream: exact latency + order implies consecutive cycles
    for (int i = 0; i < 8; i++) send(WIDTH'(i), WIDTH'(3 * i), 1'b0, 1'b0, 1, 0);
    idle(8, 0);

    // Backpressure: fill, then stall 5 cycles with a beat offered
    for (int i = 1; i <= 6; i++) send(WIDTH'(i * 100), WIDTH'(i), 1'b0, 1'b0, 0, 0);
    in_a = 32'hABCD_0000; in_b = 32'h1234; in_cin = 1'b1; in_sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(32'hABCD_0000, 32'h1234, 1'b1, 1'b0, 0, 0);
    idle(12, 0);
    chk("bp_drained", sb.size(), 0);

    // Reset with beats in flight: asynchronous clear, then fresh latency
    for (int i = 1; i <= 5; i++) send(WIDTH'(i * 7 + 1), WIDTH'(i), 1'b0, 1'b0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", out_sum, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1, 0);
    idle(10, 0);
    chk("post_rst_drained", sb.size(), 0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1, 1);
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
    end
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Splits a WIDTH-bit operation into NSEG = WIDTH/SEG_W segments. Each segment is resolved by a combinational SEG_W-bit lookahead slice in its own pipeline stage, with the carry registered between stages.
- Adds a subtract mode and status flags (carry, signed overflow, zero).
- Sits in the ALU datapath as the throughput-oriented replacement for the single-cycle 32-bit adder.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG_W (elaboration error otherwise).
- SEG_W, 8, bits resolved per pipeline stage; NSEG = WIDTH/SEG_W stages, NSEG >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, used only when in_sub=0.
- in_sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of the MSB; in sub mode 1 = no borrow (A>=B unsigned).
- out_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared, so out_valid=0. out_sum, out_cout, out_ovf and all data registers go to 0; out_zero=1. Reset mid-operation discards every in-flight beat; no partial result is ever emitted.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid/out_ready).
- Input transfer: in_valid && in_ready. Stage 0 captures A, B_eff (B or ~B), and c0 (in_cin or 1). Stage 0 valid <= in_valid when adv.
- Stage k (0..NSEG-1) resolves bits [k*SEG_W +: SEG_W] from its registered carry-in.
  - Registered to stage k+1: the partial sum bits so far, the remaining unprocessed operand bits, and the segment carry-out.
  - The last stage also records the carry into the MSB, for ovf.
  - When adv=0, all stages hold; valid bits hold; no bubble is collapsed.
- Latency: NSEG cycles from input transfer to out_valid, with no stalls. Throughput: 1 beat/cycle while out_ready=1.
- out_* are registered outputs of the final stage. They are stable while out_valid && !out_ready.
- Simultaneous accept and emit in the same cycle is allowed: a full pipeline with out_ready=1 keeps streaming.
- Bubbles: in_valid=0 with adv=1 inserts an invalid slot. Invalid slots still shift and do not stall.
- Wrap-around: the sum is truncated to WIDTH. Carry and ovf are reported and never saturate.
- in_cin is ignored when in_sub=1.
- NSEG=1: single register stage, latency 1, same handshake.

Decomposition:
- Shared package addsub_pkg:
  - function computing NSEG from WIDTH and SEG_W.
  - localparams for op encoding: OP_ADD=0, OP_SUB=1.
  - packed stage-payload layout: a, b, psum, carry, valid.
- Sub-module cla_seg:
  - combinational SEG_W-bit lookahead slice.
  - inputs: a, b, cin. Outputs: s, cout, c_msb_in (carry into the slice MSB).
  - built from generate/propagate terms.
  - instantiated NSEG times via generate.

Test Plan (WIDTH=32, SEG_W=8, latency 4):
- Add with carry chain: A=32'hFFFF_FFFF, B=1, cin=0, sub=0 -> 4 cycles later out_sum=0, out_cout=1, out_zero=1, out_ovf=0.
- Signed overflow: A=32'h7FFF_FFFF, B=1, add -> out_sum=32'h8000_0000, ovf=1, cout=0. Then A=5, B=7, sub -> out_sum=32'hFFFF_FFFE, cout=0 (borrow), ovf=0.
- Back-to-back stream: 8 beats A=i, B=3i with out_ready=1 -> results appear on 8 consecutive cycles starting at cycle 4, in order, each sum = 4i.
- Backpressure:
  - stimulus: fill the pipeline, then hold out_ready=0 for 5 cycles.
  - in_ready=0 for the whole stall; out_sum is held stable.
  - no beat is lost or duplicated after out_ready returns to 1.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 and out_sum=0 immediately, without waiting for a clock edge. After release, the first new beat appears exactly 4 cycles after its acceptance.
- Random: 10k random A/B/cin/sub beats with random in_valid/out_ready -> every beat matches a reference model for all four result outputs.
